pipe_hazard_ctrl: RTL

Hazard scheduler for the decode/parameter-fetch stage of the core pipeline. Keeps a small scoreboard of in-flight instructions that write TPC, IPC or FLAG, using the effect flags the decode stage produces. Compares the dependency flags of the instruction now in decode against that scoreboard. Drives the decode-stage `isStop`, injects bubbles downstream, and freezes the whole pipe on an external memory stall.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 22 ++
 rtl/pipe_hazard_ctrl_scoreboard.sv | 44 ++++
 rtl/pipe_hazard_ctrl.sv | 99 +++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared core definitions for the hazard scheduler:
// register channel ids, scoreboard slot layout and FSM encoding.
package pipe_hazard_ctrl_pkg;

    localparam logic [3:0] REG_FLAG = 4'd9;
    localparam logic [3:0] REG_TPC  = 4'd11;
    localparam logic [3:0] REG_IPC  = 4'd12;
    localparam logic [3:0] REG_SP   = 4'd13;

    typedef struct packed {
        logic v;
        logic tpc;
        logic ipc;
        logic flg;
    } slot_t;

    typedef enum logic {
        RUN = 1'b0,
        HAZ = 1'b1
    } state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// In-flight writer tracker: DEPTH-slot shift register, slot 0 youngest,
// with per-channel "pending write" aggregates.
module hazard_scoreboard
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  advance,
    input  logic  clear,
    input  slot_t ins,
    output logic  any_t,
    output logic  any_i,
    output logic  any_f
);

    slot_t slots [DEPTH];

    // Shift writers toward retirement; a clear empties every slot
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
        end else if (advance) begin
            for (int i = DEPTH - 1; i > 0; i--) slots[i] <= slots[i-1];
            slots[0] <= ins;
        end
    end

    // OR together the pending writes of every occupied slot
    always_comb begin
        any_t = 1'b0;
        any_i = 1'b0;
        any_f = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            any_t = any_t | (slots[i].v & slots[i].tpc);
            any_i = any_i | (slots[i].v & slots[i].ipc);
            any_f = any_f | (slots[i].v & slots[i].flg);
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Decode-stage hazard scheduler: stalls decode on TPC/IPC/FLAG
// dependencies, injects bubbles, freezes the pipe on memory stall.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec_valid,
    input  logic             dec_isDepTPC,
    input  logic             dec_isDepIPC,
    input  logic             dec_isDepFlag,
    input  logic             dec_isEffTPC,
    input  logic             dec_isEffIPC,
    input  logic             dec_isEffFlag,
    input  logic             dec_isFourCycle,
    input  logic             ext_stall,
    input  logic             flush,
    output logic             dec_stop,
    output logic             ex_bubble,
    output logic             pipe_stop,
    output logic             haz_busy,
    output logic [CNT_W-1:0] haz_cnt
);

    logic   any_t;
    logic   any_i;
    logic   any_f;
    logic   hazard;
    logic   issue;
    logic   advance;
    slot_t  ins;
    state_t state;

    // Zero-latency dependency check and issue decision
    always_comb begin
        hazard = dec_valid &
                 ((dec_isDepTPC  & any_t) |
                  (dec_isDepIPC  & any_i) |
                  (dec_isDepFlag & any_f));
        issue   = dec_valid & ~hazard & ~ext_stall & ~flush;
        advance = ~ext_stall & ~flush;
        ins     = '0;
        if (issue && dec_isFourCycle) begin
            ins = '{v: 1'b1,
                    tpc: dec_isEffTPC,
                    ipc: dec_isEffIPC,
                    flg: dec_isEffFlag};
        end
    end

    hazard_scoreboard #(
        .DEPTH (DEPTH)
    ) u_sb (
        .clk     (clk),
        .rst     (rst),
        .advance (advance),
        .clear   (flush),
        .ins     (ins),
        .any_t   (any_t),
        .any_i   (any_i),
        .any_f   (any_f)
    );

    // Stall controls follow the hazard directly, never the state
    always_comb begin
        dec_stop  = hazard | ext_stall;
        ex_bubble = hazard & ~ext_stall & ~flush;
        pipe_stop = ext_stall & ~flush;
        haz_busy  = (state == HAZ);
    end

    // Status FSM: flush wins, external stall freezes it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
        end else if (flush) begin
            state <= RUN;
        end else if (!ext_stall) begin
            unique case (state)
                RUN: if (hazard) state <= HAZ;
                HAZ: if (!hazard) state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    // Saturating count of bubble cycles caused by data hazards
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            haz_cnt <= '0;
        end else if (ex_bubble && (haz_cnt != '1)) begin
            haz_cnt <= haz_cnt + CNT_W'(1);
        end
    end

endmodule
